// File: rtl/ucdp_clk_pkg.sv
// ----------------------------------------------------------------------------
// ucdp_clk_pkg
// Shared types and limits for the ucdp clock-primitive family.
//   state_e   : handshake/run state of the divider FSM (IDLE, RUN, ACK)
//   fsm_t     : state plus the independent "output clock running" flag
//   MAX_WIDTH : largest supported divisor field width
//   width_ok  : legality check for a divisor width parameter
// ----------------------------------------------------------------------------
package ucdp_clk_pkg;

    localparam int unsigned MAX_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    // The ACK state says nothing about whether the divided clock is toggling,
    // so the run flag is carried alongside and decides where ACK returns to.
    typedef struct packed {
        state_e state;
        logic   run;
    } fsm_t;

    function automatic logic width_ok(input int width);
        return (width >= 1) && (width <= int'(MAX_WIDTH));
    endfunction

endpackage

// File: rtl/ucdp_clk_div_cnt.sv
// ----------------------------------------------------------------------------
// ucdp_clk_div_cnt
// Phase counter of the integer clock divider. Counts 0..div_i while running;
// each output phase therefore lasts div_i+1 source cycles.
// Ports:
//   clk_i      : source clock
//   rst_an_i   : asynchronous reset, active-low
//   run_i      : counter active (divided clock running); held at 0 otherwise
//   phase_i    : current level of the divided clock
//   div_i      : active divisor (registered copy owned by the top)
//   tc_o       : terminal count, phase ends on the next edge
//   boundary_o : terminal count in the low phase, next edge would be rising
// ----------------------------------------------------------------------------
module ucdp_clk_div_cnt
    import ucdp_clk_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_an_i,
    input  logic             run_i,
    input  logic             phase_i,
    input  logic [WIDTH-1:0] div_i,
    output logic             tc_o,
    output logic             boundary_o
);

    if (!width_ok(WIDTH)) begin : g_width_err
        $error("ucdp_clk_div_cnt: WIDTH must be in 1..%0d", MAX_WIDTH);
    end

    logic [WIDTH-1:0] cnt_q;

    // Terminal count only matters while running; an idle divider has no phase.
    always_comb begin
        tc_o       = run_i && (cnt_q == div_i);
        boundary_o = tc_o && !phase_i;
    end

    // Wrap at terminal count and park at zero while idle, so a restart always
    // begins with a full-length high phase.
    always_ff @(posedge clk_i or negedge rst_an_i) begin
        if (!rst_an_i) begin
            cnt_q <= '0;
        end else if (!run_i || tc_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/ucdp_clk_div.sv
// ----------------------------------------------------------------------------
// ucdp_clk_div
// Glitch-free integer clock divider with a registered 50% duty output.
// Output period is 2*(div+1) source cycles. Start/stop on en_i happens only at
// period boundaries so no runt pulses are produced; divisor updates use a
// 4-phase req/ack handshake and take effect at the next rising output edge.
// Parameters:
//   WIDTH   : divisor field width, 1..16
//   DIV_RST : divisor loaded at reset, must be < 2**WIDTH
// Ports:
//   clk_i    : source clock
//   rst_an_i : asynchronous reset, active-low
//   en_i     : run enable, level-sensitive
//   div_i    : requested divisor, stable while req_i is high
//   req_i    : ratio-update request
//   ack_o    : ratio-update acknowledge
//   busy_o   : divided clock running
//   tick_o   : one-cycle pulse in the first high cycle of clk_o
//   clk_o    : divided clock, straight from a flop
// Optional build macro:
//   UCDP_CLK_DIV_CHECK_EN (together with SIM) adds simulation-only checkers
//   for a corrupt source clock and for div_i changing during a request.
// ----------------------------------------------------------------------------
module ucdp_clk_div
    import ucdp_clk_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int DIV_RST = 0
) (
    input  logic             clk_i,
    input  logic             rst_an_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] div_i,
    input  logic             req_i,
    output logic             ack_o,
    output logic             busy_o,
    output logic             tick_o,
    output logic             clk_o
);

    fsm_t             fsm_q;
    logic [WIDTH-1:0] div_q;
    logic             tc;
    logic             boundary;
    logic             run_nxt;
    logic             load;

    ucdp_clk_div_cnt #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk_i      (clk_i),
        .rst_an_i   (rst_an_i),
        .run_i      (fsm_q.run),
        .phase_i    (clk_o),
        .div_i      (div_q),
        .tc_o       (tc),
        .boundary_o (boundary)
    );

    // The run decision and the divisor load are independent: a stop and a
    // load can coincide at one boundary. A load is accepted immediately when
    // idle, otherwise only at a boundary so the new ratio starts on a rising
    // edge. While ACK is held, further requests are ignored.
    always_comb begin
        run_nxt = fsm_q.run;
        if (!fsm_q.run && en_i) begin
            run_nxt = 1'b1;
        end else if (boundary && !en_i) begin
            run_nxt = 1'b0;
        end
        load = (fsm_q.state != ST_ACK) && req_i && (!fsm_q.run || boundary);
    end

    // Divided clock generation and handshake FSM; every output is a flop.
    always_ff @(posedge clk_i or negedge rst_an_i) begin
        if (!rst_an_i) begin
            fsm_q.state <= ST_IDLE;
            fsm_q.run   <= 1'b0;
            div_q       <= WIDTH'(DIV_RST);
            clk_o       <= 1'b0;
            tick_o      <= 1'b0;
            ack_o       <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            fsm_q.run <= run_nxt;
            busy_o    <= run_nxt;
            tick_o    <= 1'b0;

            if (!fsm_q.run) begin
                if (en_i) begin
                    clk_o  <= 1'b1;
                    tick_o <= 1'b1;
                end
            end else if (tc) begin
                if (clk_o) begin
                    clk_o <= 1'b0;
                end else if (en_i) begin
                    clk_o  <= 1'b1;
                    tick_o <= 1'b1;
                end
            end

            if (load) begin
                div_q       <= div_i;
                fsm_q.state <= ST_ACK;
                ack_o       <= 1'b1;
            end else if ((fsm_q.state == ST_ACK) && req_i) begin
                ack_o <= 1'b1;
            end else begin
                fsm_q.state <= run_nxt ? ST_RUN : ST_IDLE;
                ack_o       <= 1'b0;
            end
        end
    end

`ifdef UCDP_CLK_DIV_CHECK_EN
`ifdef SIM
    // Simulation-only: report a source clock going X/Z once it has been seen
    // toggling cleanly, once per episode.
    logic seen_zero     = 1'b0;
    logic seen_one      = 1'b0;
    logic corrupt_noted = 1'b0;

    always @(clk_i) begin
        if (clk_i === 1'b0) begin
            seen_zero     = 1'b1;
            corrupt_noted = 1'b0;
        end else if (clk_i === 1'b1) begin
            seen_one      = 1'b1;
            corrupt_noted = 1'b0;
        end else if (seen_zero && seen_one && !corrupt_noted) begin
            $display("SIMERROR: Corrupt Clock");
            corrupt_noted = 1'b1;
        end
    end

    // Simulation-only: the divisor must not move while a request waits for
    // its acknowledge.
    logic [WIDTH-1:0] div_prev = '0;
    logic             req_prev = 1'b0;

    always @(posedge clk_i) begin
        if (req_i && req_prev && !ack_o && (div_i !== div_prev)) begin
            $display("SIMERROR: div_i unstable");
        end
        div_prev <= div_i;
        req_prev <= req_i;
    end
`endif
`else
    // No checkers in the default build.
`endif

endmodule

// File: tb/tb_ucdp_clk_div.sv
// ----------------------------------------------------------------------------
// tb_ucdp_clk_div
// Directed bench for ucdp_clk_div with WIDTH=4, DIV_RST=0. Inputs change and
// outputs are sampled on the falling edge of clk_i.
// ----------------------------------------------------------------------------
module tb_ucdp_clk_div;

    localparam int WIDTH = 4;

    logic             clk_i = 1'b0;
    logic             rst_an_i;
    logic             en_i;
    logic [WIDTH-1:0] div_i;
    logic             req_i;
    logic             ack_o;
    logic             busy_o;
    logic             tick_o;
    logic             clk_o;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk_i = ~clk_i;

    ucdp_clk_div #(
        .WIDTH   (WIDTH),
        .DIV_RST (0)
    ) dut (
        .clk_i    (clk_i),
        .rst_an_i (rst_an_i),
        .en_i     (en_i),
        .div_i    (div_i),
        .req_i    (req_i),
        .ack_o    (ack_o),
        .busy_o   (busy_o),
        .tick_o   (tick_o),
        .clk_o    (clk_o)
    );

    // Counts consecutive samples at the given clk_o level, starting with the
    // current one; stops on the first sample at the other level.
    task automatic count_phase(input logic level, output int n);
        n = 0;
        while (clk_o === level && n < 200) begin
            n++;
            @(negedge clk_i);
        end
    endtask

    // Waits (bounded) until ack_o reaches the given level.
    task automatic wait_ack(input logic level, output int waited);
        waited = 0;
        while (ack_o !== level && waited < 200) begin
            @(negedge clk_i);
            waited++;
        end
    endtask

    task automatic test_reset;
        rst_an_i = 1'b0;
        en_i     = 1'b0;
        req_i    = 1'b0;
        div_i    = '0;
        repeat (3) @(negedge clk_i);
        tests_run++;
        if (clk_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_clk_o: got %b expected 0", clk_o); end
        tests_run++;
        if (tick_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_tick_o: got %b expected 0", tick_o); end
        tests_run++;
        if (ack_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_ack_o: got %b expected 0", ack_o); end
        tests_run++;
        if (busy_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy_o: got %b expected 0", busy_o); end
        rst_an_i = 1'b1;
        en_i     = 1'b1;
        @(negedge clk_i);
        tests_run++;
        if (clk_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL start_latency_clk_o: got %b expected 1", clk_o); end
        tests_run++;
        if (busy_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL start_busy_o: got %b expected 1", busy_o); end
    endtask

    task automatic test_divide_by_two;
        logic exp;
        for (int k = 0; k < 6; k++) begin
            exp = (k % 2 == 0);
            tests_run++;
            if (clk_o !== exp) begin tests_failed++; $display("[TB] FAIL div2_clk_o[%0d]: got %b expected %b", k, clk_o, exp); end
            tests_run++;
            if (tick_o !== exp) begin tests_failed++; $display("[TB] FAIL div2_tick_o[%0d]: got %b expected %b", k, tick_o, exp); end
            @(negedge clk_i);
        end
    endtask

    task automatic test_ratio_change;
        int n;
        if (clk_o !== 1'b1) @(negedge clk_i);
        div_i = 4'd3;
        req_i = 1'b1;
        @(negedge clk_i);
        tests_run++;
        if (ack_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL ratio_ack_early: got %b expected 0", ack_o); end
        @(negedge clk_i);
        tests_run++;
        if (ack_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL ratio_ack_at_boundary: got %b expected 1", ack_o); end
        tests_run++;
        if (tick_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL ratio_tick_at_boundary: got %b expected 1", tick_o); end
        req_i = 1'b0;
        count_phase(1'b1, n);
        tests_run++;
        if (n !== 4) begin tests_failed++; $display("[TB] FAIL ratio_first_high: got %0d expected 4", n); end
        tests_run++;
        if (ack_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL ratio_ack_release: got %b expected 0", ack_o); end
        count_phase(1'b0, n);
        tests_run++;
        if (n !== 4) begin tests_failed++; $display("[TB] FAIL ratio_first_low: got %0d expected 4", n); end
        count_phase(1'b1, n);
        tests_run++;
        if (n !== 4) begin tests_failed++; $display("[TB] FAIL ratio_second_high: got %0d expected 4", n); end
        count_phase(1'b0, n);
        tests_run++;
        if (n !== 4) begin tests_failed++; $display("[TB] FAIL ratio_second_low: got %0d expected 4", n); end
    endtask

    task automatic test_stop_start;
        int n;
        int w;
        logic seen_high;
        div_i = 4'd2;
        req_i = 1'b1;
        wait_ack(1'b1, w);
        tests_run++;
        if (w !== 8) begin tests_failed++; $display("[TB] FAIL stop_load_wait: got %0d expected 8", w); end
        req_i = 1'b0;
        @(negedge clk_i);
        tests_run++;
        if (ack_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL stop_ack_fall_next_cycle: got %b expected 0", ack_o); end
        en_i = 1'b0;
        count_phase(1'b1, n);
        tests_run++;
        if (n !== 2) begin tests_failed++; $display("[TB] FAIL stop_high_completes: got %0d expected 2", n); end
        tests_run++;
        if (busy_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL stop_busy_in_low: got %b expected 1", busy_o); end
        repeat (3) @(negedge clk_i);
        tests_run++;
        if (busy_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL stop_busy_after_low: got %b expected 0", busy_o); end
        seen_high = 1'b0;
        repeat (6) begin
            @(negedge clk_i);
            if (clk_o !== 1'b0) seen_high = 1'b1;
        end
        tests_run++;
        if (seen_high !== 1'b0) begin tests_failed++; $display("[TB] FAIL stop_clk_stays_low: got %b expected 0", seen_high); end
        en_i = 1'b1;
        @(negedge clk_i);
        tests_run++;
        if (clk_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL restart_clk_o: got %b expected 1", clk_o); end
        tests_run++;
        if (tick_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL restart_tick_o: got %b expected 1", tick_o); end
        count_phase(1'b1, n);
        tests_run++;
        if (n !== 3) begin tests_failed++; $display("[TB] FAIL restart_high: got %0d expected 3", n); end
    endtask

    task automatic test_stop_with_update;
        int n;
        int w;
        en_i  = 1'b0;
        req_i = 1'b1;
        div_i = 4'd15;
        wait_ack(1'b1, w);
        tests_run++;
        if (w !== 3) begin tests_failed++; $display("[TB] FAIL stopupd_ack_wait: got %0d expected 3", w); end
        tests_run++;
        if (clk_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL stopupd_clk_o: got %b expected 0", clk_o); end
        tests_run++;
        if (busy_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL stopupd_busy_o: got %b expected 0", busy_o); end
        req_i = 1'b0;
        @(negedge clk_i);
        tests_run++;
        if (ack_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL stopupd_ack_release: got %b expected 0", ack_o); end
        en_i = 1'b1;
        @(negedge clk_i);
        tests_run++;
        if (clk_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL stopupd_restart: got %b expected 1", clk_o); end
        count_phase(1'b1, n);
        tests_run++;
        if (n !== 16) begin tests_failed++; $display("[TB] FAIL stopupd_high: got %0d expected 16", n); end
        count_phase(1'b0, n);
        tests_run++;
        if (n !== 16) begin tests_failed++; $display("[TB] FAIL stopupd_low: got %0d expected 16", n); end
    endtask

    task automatic test_async_reset;
        int n;
        int w;
        div_i = 4'd5;
        req_i = 1'b1;
        wait_ack(1'b1, w);
        tests_run++;
        if (w !== 32) begin tests_failed++; $display("[TB] FAIL arst_ack_wait: got %0d expected 32", w); end
        tests_run++;
        if (tick_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL arst_tick_at_load: got %b expected 1", tick_o); end
        repeat (2) @(negedge clk_i);
        tests_run++;
        if (clk_o !== 1'b1 || ack_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL arst_mid_phase: got clk_o=%b ack_o=%b expected 1 1", clk_o, ack_o); end
        #2 rst_an_i = 1'b0;
        #1;
        tests_run++;
        if (clk_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL arst_clk_o: got %b expected 0", clk_o); end
        tests_run++;
        if (ack_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL arst_ack_o: got %b expected 0", ack_o); end
        tests_run++;
        if (busy_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL arst_busy_o: got %b expected 0", busy_o); end
        req_i = 1'b0;
        @(negedge clk_i);
        rst_an_i = 1'b1;
        @(negedge clk_i);
        tests_run++;
        if (clk_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL arst_restart: got %b expected 1", clk_o); end
        count_phase(1'b1, n);
        tests_run++;
        if (n !== 1) begin tests_failed++; $display("[TB] FAIL arst_div_rst_high: got %0d expected 1", n); end
        count_phase(1'b0, n);
        tests_run++;
        if (n !== 1) begin tests_failed++; $display("[TB] FAIL arst_div_rst_low: got %0d expected 1", n); end
    endtask

    initial begin
        test_reset();
        test_divide_by_two();
        test_ratio_change();
        test_stop_start();
        test_stop_with_update();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Runaway guard.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
